// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scan controller for an up-to-8-digit common-anode
// seven-segment display. Each dwell period one digit is selected: its 4-bit
// code, its index and the decimal-point pattern are presented to the
// downstream segment decoder, and its active-low anode is driven low once the
// anti-ghosting blanking interval at the start of the dwell has elapsed.
// Inputs are snapshotted once per frame so a frame is always self-consistent.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   asynchronous, active-high reset
//   digits_in     in  32   nibble k = code for digit k
//   digit_en_in   in   8   bit k = 1: digit k may light
//   dp_in         in   8   decimal-point pattern, active-low
//   blink_mask_in in   8   bit k = 1: digit k blinks
//   num_out       out  4   code of the selected digit
//   digit_out     out  4   index of the selected digit
//   en_p_out      out  8   snapshotted decimal-point pattern
//   an_out        out  8   anode enables, active-low (one-hot-low or all-high)
//   frame_start   out  1   one-cycle pulse when the index wraps to 0
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_en_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blink_mask_in,
  output logic [3:0]  num_out,
  output logic [3:0]  digit_out,
  output logic [7:0]  en_p_out,
  output logic [7:0]  an_out,
  output logic        frame_start
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST    = 3'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST     = FR_W'(BLINK_FRAMES - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic             blink_phase_q, blink_phase_d;

  // Per-frame input snapshot
  logic [31:0] snap_digits_q, snap_digits_d;
  logic [7:0]  snap_en_q, snap_en_d;
  logic [7:0]  snap_dp_q, snap_dp_d;
  logic [7:0]  snap_blink_q, snap_blink_d;

  // Registered outputs
  logic [3:0] num_q, num_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] en_p_q, en_p_d;
  logic [7:0] an_q, an_d;
  logic       frame_start_q, frame_start_d;

  logic wrap;
  logic light;

  // Outputs are computed from the *next* state so that index, code, dp and
  // anode all change on the same edge as idx/cnt with no skew between them.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in combinational logic infers a latch.
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    snap_dp_d     = snap_dp_q;
    snap_blink_d  = snap_blink_q;
    wrap          = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Snapshot load and blink toggle coincide with the wrap, so digit 0 of
    // the new frame already sees the new snapshot and the new blink phase.
    if (wrap) begin
      snap_digits_d = digits_in;
      snap_en_d     = digit_en_in;
      snap_dp_d     = dp_in;
      snap_blink_d  = blink_mask_in;
      if (frame_q == FR_LAST) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    light = (cnt_d >= BLANK_START) && snap_en_d[idx_d] &&
            !(blink_phase_d && snap_blink_d[idx_d]);

    an_d = 8'hFF;
    if (light) an_d[idx_d] = 1'b0;

    num_d         = snap_digits_d[{idx_d, 2'b00} +: 4];
    digit_d       = {1'b0, idx_d};
    en_p_d        = snap_dp_d;
    frame_start_d = wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= 8'hFF;
      snap_blink_q  <= '0;
      num_q         <= '0;
      digit_q       <= '0;
      en_p_q        <= 8'hFF;
      an_q          <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      num_q         <= num_d;
      digit_q       <= digit_d;
      en_p_q        <= en_p_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign num_out     = num_q;
  assign digit_out   = digit_q;
  assign en_p_out    = en_p_q;
  assign an_out      = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with NUM_DIGITS=8, DWELL_CYCLES=10,
// BLANK_CYCLES=2, BLINK_FRAMES=2. Time t counts rising edges since reset
// release (t=0 is the reset state); outputs are sampled on the falling edge.
// With these parameters: digit index = (t/10)%8, dwell cycle = t%10,
// frame = t/80, frame_start high when t%80 == 0 and t > 0.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  digit_en_in = '0;
  logic [7:0]  dp_in = 8'hFF;
  logic [7:0]  blink_mask_in = '0;
  logic [3:0]  num_out;
  logic [3:0]  digit_out;
  logic [7:0]  en_p_out;
  logic [7:0]  an_out;
  logic        frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_driver #(
    .NUM_DIGITS  (8),
    .DWELL_CYCLES(10),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_in    (digits_in),
    .digit_en_in  (digit_en_in),
    .dp_in        (dp_in),
    .blink_mask_in(blink_mask_in),
    .num_out      (num_out),
    .digit_out    (digit_out),
    .en_p_out     (en_p_out),
    .an_out       (an_out),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Expected anodes at time t for a run whose inputs are held from reset.
  // Frame 0 is dark; blink phase flips on every 2nd frame_start pulse, so it
  // is 1 during frames 2,3, 6,7, ...
  function automatic logic [7:0] m_an(int t, logic [7:0] en, logic [7:0] bl);
    int  f, k, c;
    logic ph;
    f = t / 80;
    k = (t / 10) % 8;
    c = t % 10;
    ph = ((f / 2) % 2) == 1;
    m_an = 8'hFF;
    if (f > 0 && c >= 2 && en[k] && !(ph && bl[k])) m_an[k] = 1'b0;
  endfunction

  // Apply inputs, pulse reset, release on a falling edge: returns at t=0.
  task automatic do_reset(input logic [31:0] d, input logic [7:0] en,
                          input logic [7:0] dp, input logic [7:0] bl);
    digits_in = d; digit_en_in = en; dp_in = dp; blink_mask_in = bl;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset;
    digits_in = 32'h76543210; digit_en_in = 8'hFF; dp_in = 8'h00;
    #2 rst = 1'b1;
    #1;
    n_assert++; if (an_out !== 8'hFF) begin n_fail++; $display("FAIL reset_an got %h want ff", an_out); end
    n_assert++; if (num_out !== 4'h0) begin n_fail++; $display("FAIL reset_num got %h want 0", num_out); end
    n_assert++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL reset_digit got %h want 0", digit_out); end
    n_assert++; if (en_p_out !== 8'hFF) begin n_fail++; $display("FAIL reset_enp got %h want ff", en_p_out); end
    n_assert++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", frame_start); end
    repeat (3) @(negedge clk);
    n_assert++; if (an_out !== 8'hFF || digit_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_held an=%h digit=%h want ff/0", an_out, digit_out);
    end
    @(negedge clk); rst = 1'b0;
    // No pulse on reset exit and digit 0 held for the whole first dwell.
    for (int t = 1; t < 10; t++) begin
      @(negedge clk);
      n_assert++; if (frame_start !== 1'b0 || digit_out !== 4'h0) begin
        n_fail++; $display("FAIL reset_exit t=%0d fs=%b digit=%h want 0/0", t, frame_start, digit_out);
      end
    end
  endtask

  task automatic test_scan;
    logic [7:0] ea;
    logic [3:0] en_num;
    do_reset(32'h76543210, 8'hFF, 8'hFF, 8'h00);
    for (int t = 0; t < 240; t++) begin
      if (t > 0) @(negedge clk);
      ea = m_an(t, 8'hFF, 8'h00);
      en_num = (t < 80) ? 4'h0 : 4'((t / 10) % 8);
      n_assert++; if (an_out !== ea) begin n_fail++; $display("FAIL scan_an t=%0d got %h want %h", t, an_out, ea); end
      n_assert++; if (digit_out !== 4'((t / 10) % 8)) begin
        n_fail++; $display("FAIL scan_digit t=%0d got %h want %h", t, digit_out, 4'((t / 10) % 8));
      end
      n_assert++; if (num_out !== en_num) begin n_fail++; $display("FAIL scan_num t=%0d got %h want %h", t, num_out, en_num); end
      n_assert++; if (frame_start !== (t > 0 && t % 80 == 0)) begin
        n_fail++; $display("FAIL scan_fs t=%0d got %b want %b", t, frame_start, (t > 0 && t % 80 == 0));
      end
    end
  endtask

  task automatic test_snapshot;
    logic [3:0] en_num;
    do_reset(32'h76543210, 8'hFF, 8'hFF, 8'h00);
    for (int t = 0; t < 240; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 110) digits_in = 32'hFFFFFFFF;  // mid-frame 1, idx 3
      if (t < 80)       en_num = 4'h0;
      else if (t < 160) en_num = 4'((t / 10) % 8);
      else              en_num = 4'hF;
      n_assert++; if (num_out !== en_num) begin n_fail++; $display("FAIL snap_num t=%0d got %h want %h", t, num_out, en_num); end
    end
  endtask

  task automatic test_enable;
    logic [7:0] ea;
    do_reset(32'h76543210, 8'b1010_1010, 8'hFF, 8'h00);
    for (int t = 0; t < 240; t++) begin
      if (t > 0) @(negedge clk);
      ea = m_an(t, 8'b1010_1010, 8'h00);
      n_assert++; if (an_out !== ea) begin n_fail++; $display("FAIL enable_an t=%0d got %h want %h", t, an_out, ea); end
    end
  endtask

  task automatic test_blink;
    logic [7:0] ea;
    do_reset(32'h76543210, 8'hFF, 8'hFF, 8'h01);
    // Digit 0 lit in frames 1,4,5 and dark in frames 0,2,3,6.
    for (int t = 0; t < 560; t++) begin
      if (t > 0) @(negedge clk);
      ea = m_an(t, 8'hFF, 8'h01);
      n_assert++; if (an_out !== ea) begin n_fail++; $display("FAIL blink_an t=%0d got %h want %h", t, an_out, ea); end
    end
  endtask

  task automatic test_dp;
    logic [7:0] ep;
    do_reset(32'h76543210, 8'hFF, 8'b1111_1011, 8'h00);
    for (int t = 0; t < 160; t++) begin
      if (t > 0) @(negedge clk);
      ep = (t < 80) ? 8'hFF : 8'hFB;
      n_assert++; if (en_p_out !== ep) begin n_fail++; $display("FAIL dp_enp t=%0d got %h want %h", t, en_p_out, ep); end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_reset(32'h76543210, 8'hFF, 8'b1111_1011, 8'h00);
    repeat (136) @(negedge clk);  // t=136: frame 1, idx 5, cnt 6
    n_assert++; if (an_out !== 8'hDF) begin n_fail++; $display("FAIL mid_pre_an got %h want df", an_out); end
    rst = 1'b1;
    #1;
    n_assert++; if (an_out !== 8'hFF) begin n_fail++; $display("FAIL mid_an got %h want ff", an_out); end
    n_assert++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL mid_digit got %h want 0", digit_out); end
    n_assert++; if (num_out !== 4'h0) begin n_fail++; $display("FAIL mid_num got %h want 0", num_out); end
    n_assert++; if (en_p_out !== 8'hFF) begin n_fail++; $display("FAIL mid_enp got %h want ff", en_p_out); end
    @(negedge clk); rst = 1'b0;
    seen = -1;
    for (int t = 1; t <= 200 && seen < 0; t++) begin
      @(negedge clk);
      if (t < 80) begin
        n_assert++; if (an_out !== 8'hFF) begin n_fail++; $display("FAIL mid_dark t=%0d got %h want ff", t, an_out); end
      end
      if (frame_start === 1'b1) seen = t;
    end
    n_assert++; if (seen != 80) begin n_fail++; $display("FAIL mid_fs_time got %0d want 80", seen); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_enable();
    test_blink();
    test_dp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
